// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command framer.
// Holds the TX framing state encoding, the default frame geometry and
// gap timeout, the UART bit period, and a small width helper.
package uart_cmd_pkg;

  localparam int CMD_BYTES_DEF   = 2;
  localparam int RESP_BYTES_DEF  = 1;
  localparam int GAP_TIMEOUT_DEF = 200000;

  // clk cycles per UART bit
  localparam int BAUD_DIV = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_framer_uart.sv
// Byte-level UART (8N1) used by the command framer.
// Ports:
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_rx            serial receive line (synchronised internally)
//   o_tx            serial transmit line, idle high
//   i_trmt          one-cycle request to send i_tx_data (ignored while sending)
//   i_tx_data       byte to send
//   o_tx_done       level, set when a byte has fully left, cleared on i_trmt
//   i_clr_rx_rdy    consumer acknowledge for o_rx_rdy
//   o_rx_rdy        level, a received byte is waiting on o_rx_data
//   o_rx_data       last received byte
module uart_cmd_framer_uart
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV_P = BAUD_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_tx,
  input  logic       i_trmt,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_done,
  input  logic       i_clr_rx_rdy,
  output logic       o_rx_rdy,
  output logic [7:0] o_rx_data
);

  localparam int            BW        = cnt_w(BAUD_DIV_P);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV_P - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV_P / 2);

  // ---------------- receiver ----------------
  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_busy;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_rdy;
  logic [7:0]    r_rx_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_rdy   <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      if (i_clr_rx_rdy) r_rx_rdy <= 1'b0;
      if (!r_rx_busy) begin
        // Falling edge on an idle line: aim the first sample at mid start bit.
        if (!r_rx_sync) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= BAUD_HALF;
          r_rx_bit  <= 4'd0;
        end
      end else if (r_rx_baud != '0) begin
        r_rx_baud <= r_rx_baud - BW'(1);
      end else begin
        r_rx_baud <= BAUD_LAST;
        if (r_rx_bit == 4'd0) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (r_rx_sync) r_rx_busy <= 1'b0;
          else           r_rx_bit  <= 4'd1;
        end else if (r_rx_bit == 4'd9) begin
          r_rx_busy <= 1'b0;
          // Only a valid stop bit delivers the byte; the set beats a stale clear.
          if (r_rx_sync) begin
            r_rx_data <= r_rx_shift;
            r_rx_rdy  <= 1'b1;
          end
        end else begin
          r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 4'd1;
        end
      end
    end
  end

  assign o_rx_rdy  = r_rx_rdy;
  assign o_rx_data = r_rx_data;

  // ---------------- transmitter ----------------
  logic [9:0]    r_tx_shift;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bits;
  logic          r_tx_busy;
  logic          r_tx_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_shift <= '1;
      r_tx_baud  <= '0;
      r_tx_bits  <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else if (!r_tx_busy) begin
      if (i_trmt) begin
        r_tx_shift <= {1'b1, i_tx_data, 1'b0};
        r_tx_baud  <= BAUD_LAST;
        r_tx_bits  <= 4'd10;
        r_tx_busy  <= 1'b1;
        r_tx_done  <= 1'b0;
      end
    end else if (r_tx_baud != '0) begin
      r_tx_baud <= r_tx_baud - BW'(1);
    end else if (r_tx_bits == 4'd1) begin
      // Stop bit stays in bit 0, so the line rests high afterwards.
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b1;
    end else begin
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      r_tx_bits  <= r_tx_bits - 4'd1;
      r_tx_baud  <= BAUD_LAST;
    end
  end

  assign o_tx      = r_tx_shift[0];
  assign o_tx_done = r_tx_done;

endmodule

// File: rtl/uart_cmd_framer.sv
// Multi-byte command/response framer on top of a byte UART.
// RX: bytes are gathered MSB-first into a CMD_BYTES command; a partial
// frame idle for GAP_TIMEOUT cycles is dropped with a frame_err pulse.
// TX: a RESP_BYTES response is sent MSB byte first on trmt.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   RX, TX       serial lines
//   clr_cmd_rdy  consumer acknowledge of cmd
//   cmd_rdy      a complete command is held on cmd
//   cmd          assembled command, first received byte in the MSBs
//   trmt, resp   one-cycle send request and response data
//   tx_busy      response frame in progress
//   tx_done      level, last response fully sent (until next accepted trmt)
//   frame_err    one-cycle pulse when a partial command times out
module uart_cmd_framer
  import uart_cmd_pkg::*;
#(
  parameter int CMD_BYTES   = CMD_BYTES_DEF,
  parameter int RESP_BYTES  = RESP_BYTES_DEF,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    RX,
  output logic                    TX,
  input  logic                    clr_cmd_rdy,
  output logic                    cmd_rdy,
  output logic [8*CMD_BYTES-1:0]  cmd,
  input  logic                    trmt,
  input  logic [8*RESP_BYTES-1:0] resp,
  output logic                    tx_busy,
  output logic                    tx_done,
  output logic                    frame_err
);

  localparam int               CNT_W    = cnt_w(CMD_BYTES);
  localparam int               GAP_W    = cnt_w(GAP_TIMEOUT);
  localparam int               TXC_W    = cnt_w(RESP_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);
  localparam logic [TXC_W-1:0] TXC_LAST = TXC_W'(RESP_BYTES - 1);

  logic       w_rx_rdy;
  logic [7:0] w_rx_data;
  logic       w_clr_rx_rdy;
  logic       w_uart_trmt;
  logic [7:0] w_tx_byte;
  logic       w_uart_tx_done;

  uart_cmd_framer_uart u_uart (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (RX),
    .o_tx         (TX),
    .i_trmt       (w_uart_trmt),
    .i_tx_data    (w_tx_byte),
    .o_tx_done    (w_uart_tx_done),
    .i_clr_rx_rdy (w_clr_rx_rdy),
    .o_rx_rdy     (w_rx_rdy),
    .o_rx_data    (w_rx_data)
  );

  // ---------------- RX command assembly ----------------
  logic [CNT_W-1:0]       r_count;
  logic [GAP_W-1:0]       r_gap;
  logic [8*CMD_BYTES-1:0] r_shadow;
  logic [8*CMD_BYTES-1:0] r_cmd;
  logic                   r_cmd_rdy;
  logic                   r_frame_err;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_timeout;
  logic [8*CMD_BYTES-1:0] w_shadow_next;

  // Every byte is taken the cycle it shows up.
  assign w_accept     = w_rx_rdy;
  assign w_clr_rx_rdy = w_rx_rdy;
  assign w_last       = (r_count == CNT_LAST);
  // Fires on the cycle the gap count would reach GAP_TIMEOUT; a byte
  // arriving in that same cycle keeps the frame alive.
  assign w_timeout    = (r_count != '0) && !w_accept && (r_gap == GAP_LAST);

  // Shadow with the incoming byte dropped into its lane, so the final
  // byte can go straight into cmd in the same cycle.
  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < CMD_BYTES; i++) begin
      if (int'(r_count) == CMD_BYTES - 1 - i) w_shadow_next[8*i +: 8] = w_rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_gap       <= '0;
      r_shadow    <= '0;
      r_cmd       <= '0;
      r_cmd_rdy   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_timeout;
      if (w_accept) begin
        r_shadow <= w_shadow_next;
        r_gap    <= '0;
        if (w_last) begin
          r_count <= '0;
          r_cmd   <= w_shadow_next;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (w_timeout) begin
        r_count <= '0;
        r_gap   <= '0;
      end else if (r_count != '0) begin
        r_gap <= r_gap + GAP_W'(1);
      end
      // Completion outranks any clear arriving in the same cycle.
      if (w_accept && w_last) begin
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy || (w_accept && (r_count == '0))) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign frame_err = r_frame_err;

  // ---------------- TX response framing ----------------
  tx_state_e               r_tx_state;
  tx_state_e               w_tx_next;
  logic [8*RESP_BYTES-1:0] r_tx_shift;
  logic [TXC_W-1:0]        r_tx_left;
  logic                    r_tx_busy;
  logic                    r_tx_done;
  logic                    r_uart_done_q;

  logic w_uart_done_rise;
  logic w_tx_load;
  logic w_tx_shift;
  logic w_tx_finish;

  assign w_uart_done_rise = w_uart_tx_done && !r_uart_done_q;
  assign w_tx_byte        = r_tx_shift[8*RESP_BYTES-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next   = r_tx_state;
    w_uart_trmt = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_shift  = 1'b0;
    w_tx_finish = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (trmt) begin
          w_tx_load = 1'b1;
          w_tx_next = TX_SEND;
        end
      end
      TX_SEND: begin
        w_uart_trmt = 1'b1;
        w_tx_next   = TX_WAIT;
      end
      TX_WAIT: begin
        if (w_uart_done_rise) begin
          if (r_tx_left != '0) begin
            w_tx_shift = 1'b1;
            w_tx_next  = TX_SEND;
          end else begin
            w_tx_finish = 1'b1;
            w_tx_next   = TX_IDLE;
          end
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift    <= '0;
      r_tx_left     <= '0;
      r_tx_busy     <= 1'b0;
      r_tx_done     <= 1'b0;
      r_uart_done_q <= 1'b0;
    end else begin
      r_uart_done_q <= w_uart_tx_done;
      if (w_tx_load) begin
        r_tx_shift <= resp;
        r_tx_left  <= TXC_LAST;
        r_tx_busy  <= 1'b1;
        r_tx_done  <= 1'b0;
      end else if (w_tx_shift) begin
        r_tx_shift <= r_tx_shift << 8;
        r_tx_left  <= r_tx_left - TXC_W'(1);
      end else if (w_tx_finish) begin
        r_tx_busy <= 1'b0;
        r_tx_done <= 1'b1;
      end
    end
  end

  assign tx_busy = r_tx_busy;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_cmd_framer.sv
module tb_uart_cmd_framer;
  import uart_cmd_pkg::*;

  localparam int GAP = 400;
  localparam int BIT = BAUD_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rx2, rx3, clr2, clr3, trmt2, trmt3;
  logic [15:0] resp2;
  logic [7:0]  resp3;
  logic        tx2, tx3, rdy2, rdy3, busy2, busy3, done2, done3, ferr2, ferr3;
  logic [15:0] cmd2;
  logic [23:0] cmd3;

  uart_cmd_framer #(.CMD_BYTES(2), .RESP_BYTES(2), .GAP_TIMEOUT(GAP)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .RX(rx2), .TX(tx2), .clr_cmd_rdy(clr2),
    .cmd_rdy(rdy2), .cmd(cmd2), .trmt(trmt2), .resp(resp2),
    .tx_busy(busy2), .tx_done(done2), .frame_err(ferr2));

  uart_cmd_framer #(.CMD_BYTES(3), .RESP_BYTES(1), .GAP_TIMEOUT(GAP)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .RX(rx3), .TX(tx3), .clr_cmd_rdy(clr3),
    .cmd_rdy(rdy3), .cmd(cmd3), .trmt(trmt3), .resp(resp3),
    .tx_busy(busy3), .tx_done(done3), .frame_err(ferr3));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event monitors
  int   ferr2_cnt = 0;
  int   ferr3_cnt = 0;
  int   done2_rises = 0;
  logic done2_q = 1'b0;
  always @(posedge clk) begin
    if (ferr2 === 1'b1) ferr2_cnt <= ferr2_cnt + 1;
    if (ferr3 === 1'b1) ferr3_cnt <= ferr3_cnt + 1;
    done2_q <= done2;
    if (done2 === 1'b1 && done2_q !== 1'b1) done2_rises <= done2_rises + 1;
  end

  // Reference UART receiver on the dut2 TX line
  logic [7:0] txq[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx2);
      repeat (BIT/2) @(posedge clk);
      if (tx2 == 1'b0) begin
        b = '0;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(posedge clk);
          b[i] = tx2;
        end
        repeat (BIT) @(posedge clk);
        txq.push_back(b);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_rx(input int which, input logic v);
    if (which == 2) rx2 = v;
    else            rx3 = v;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_rx(which, f[i]);
      repeat (BIT-1) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr(input int which);
    @(negedge clk);
    if (which == 2) clr2 = 1'b1; else clr3 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    clr3 = 1'b0;
  endtask

  task automatic send_trmt2(input logic [15:0] v);
    @(negedge clk);
    trmt2 = 1'b1;
    resp2 = v;
    @(negedge clk);
    trmt2 = 1'b0;
  endtask

  task automatic wait_done2();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (done2) break;
    end
    chk("tx_done_wait", 32'(done2), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0]  pend[$];
  logic [23:0] exp_cmd;
  logic        exp_rdy;
  int          exp_ferr;
  int          rises0;
  logic [15:0] v;
  logic [7:0]  b;

  initial begin
    rst_n = 1'b0; rx2 = 1'b1; rx3 = 1'b1; clr2 = 1'b0; clr3 = 1'b0;
    trmt2 = 1'b0; trmt3 = 1'b0; resp2 = '0; resp3 = '0;
    idle(5);
    chk("rst_cmd2", 32'(cmd2), 32'd0);
    chk("rst_rdy2", 32'(rdy2), 32'd0);
    chk("rst_busy2", 32'(busy2), 32'd0);
    chk("rst_done2", 32'(done2), 32'd0);
    chk("rst_ferr2", 32'(ferr2), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    chk("rst_cmd3", 32'(cmd3), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Two-byte command, exact cmd_rdy timing
    fork
      begin send_byte(2, 8'hA5); send_byte(2, 8'h3C); end
      begin
        int seen;
        seen = 0;
        for (int k = 0; k < 800; k++) begin
          @(negedge clk);
          if (u_dut2.w_rx_rdy) begin
            seen++;
            if (seen == 2) begin
              chk("a53c_rdy_before", 32'(rdy2), 32'd0);
              @(negedge clk);
              chk("a53c_rdy_after", 32'(rdy2), 32'd1);
              chk("a53c_cmd", 32'(cmd2), 32'hA53C);
              break;
            end
          end
        end
        chk("a53c_rx_rdy_seen", 32'(seen), 32'd2);
      end
    join
    idle(600);
    chk("a53c_cmd_hold", 32'(cmd2), 32'hA53C);
    chk("a53c_rdy_hold", 32'(rdy2), 32'd1);

    // New frame drops cmd_rdy at first byte, cmd held until completion
    send_byte(2, 8'hBE); send_byte(2, 8'hEF);
    chk("beef_cmd", 32'(cmd2), 32'hBEEF);
    chk("beef_rdy", 32'(rdy2), 32'd1);
    send_byte(2, 8'h01);
    chk("first_byte_rdy", 32'(rdy2), 32'd0);
    chk("first_byte_cmd", 32'(cmd2), 32'hBEEF);
    send_byte(2, 8'h02);
    chk("c0102_cmd", 32'(cmd2), 32'h0102);
    chk("c0102_rdy", 32'(rdy2), 32'd1);
    pulse_clr(2);
    chk("clr_rdy", 32'(rdy2), 32'd0);
    chk("clr_cmd", 32'(cmd2), 32'h0102);

    // Completion coinciding with clr_cmd_rdy
    send_byte(2, 8'h55);
    fork
      send_byte(2, 8'hAA);
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk);
          if (u_dut2.w_rx_rdy) begin
            clr2 = 1'b1;
            @(negedge clk);
            clr2 = 1'b0;
            break;
          end
        end
      end
    join
    chk("coincide_rdy", 32'(rdy2), 32'd1);
    chk("coincide_cmd", 32'(cmd2), 32'h55AA);

    // Three-byte command with a timed-out partial frame
    send_byte(3, 8'h11); send_byte(3, 8'h22);
    idle(GAP + 40);
    chk("gap_ferr_cnt", 32'(ferr3_cnt), 32'd1);
    chk("gap_cmd_kept", 32'(cmd3), 32'd0);
    chk("gap_rdy_kept", 32'(rdy3), 32'd0);
    send_byte(3, 8'h33); send_byte(3, 8'h44); send_byte(3, 8'h55);
    chk("c334455_cmd", 32'(cmd3), 32'h334455);
    chk("c334455_rdy", 32'(rdy3), 32'd1);
    idle(GAP + 40);
    chk("no_extra_ferr", 32'(ferr3_cnt), 32'd1);

    // Randomised RX traffic against a frame-queue model
    exp_cmd = 24'h334455; exp_rdy = 1'b1; exp_ferr = 1;
    pend.delete();
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(GAP + 50 + $urandom_range(0, 100));
        if (pend.size() > 0) begin
          exp_ferr++;
          pend.delete();
        end
      end else begin
        idle($urandom_range(0, 60));
      end
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr(3);
        exp_rdy = 1'b0;
      end
      b = 8'($urandom);
      send_byte(3, b);
      pend.push_back(b);
      if (pend.size() == 1) exp_rdy = 1'b0;
      if (pend.size() == 3) begin
        exp_cmd = {pend[0], pend[1], pend[2]};
        exp_rdy = 1'b1;
        pend.delete();
      end
      chk("rand_cmd", 32'(cmd3), 32'(exp_cmd));
      chk("rand_rdy", 32'(rdy3), 32'(exp_rdy));
      chk("rand_ferr", 32'(ferr3_cnt), 32'(exp_ferr));
    end

    // Two-byte response with an ignored mid-frame trmt
    txq.delete();
    rises0 = done2_rises;
    send_trmt2(16'hCAFE);
    chk("tx_start_n0", 32'(tx2), 32'd1);
    @(negedge clk);
    chk("tx_start_n1", 32'(tx2), 32'd0);
    chk("tx_busy_start", 32'(busy2), 32'd1);
    idle(60);
    send_trmt2(16'h1234);
    for (int k = 0; k < 400 && txq.size() < 1; k++) @(negedge clk);
    chk("tx_first_byte_seen", 32'(txq.size()), 32'd1);
    chk("tx_busy_between", 32'(busy2), 32'd1);
    chk("tx_done_between", 32'(done2), 32'd0);
    wait_done2();
    chk("cafe_nbytes", 32'(txq.size()), 32'd2);
    if (txq.size() == 2) begin
      chk("cafe_b0", 32'(txq[0]), 32'hCA);
      chk("cafe_b1", 32'(txq[1]), 32'hFE);
    end
    chk("cafe_busy_end", 32'(busy2), 32'd0);
    idle(400);
    chk("cafe_done_level", 32'(done2), 32'd1);
    chk("cafe_done_rises", 32'(done2_rises - rises0), 32'd1);
    chk("cafe_no_extra", 32'(txq.size()), 32'd2);

    // Randomised responses
    for (int n = 0; n < 4; n++) begin
      txq.delete();
      rises0 = done2_rises;
      v = 16'($urandom);
      send_trmt2(v);
      chk("rand_tx_done_clr", 32'(done2), 32'd0);
      wait_done2();
      chk("rand_tx_nbytes", 32'(txq.size()), 32'd2);
      if (txq.size() == 2) begin
        chk("rand_tx_b0", 32'(txq[0]), 32'(v[15:8]));
        chk("rand_tx_b1", 32'(txq[1]), 32'(v[7:0]));
      end
      idle(3);
      chk("rand_tx_rises", 32'(done2_rises - rises0), 32'd1);
    end

    // Reset during the second byte of an RX and a TX frame
    fork
      begin send_byte(2, 8'h77); send_byte(2, 8'h88); end
      send_trmt2(16'h5A5A);
      begin
        idle(240);
        rst_n = 1'b0;
        idle(3);
        chk("mid_rst_cmd2", 32'(cmd2), 32'd0);
        chk("mid_rst_rdy2", 32'(rdy2), 32'd0);
        chk("mid_rst_busy2", 32'(busy2), 32'd0);
        chk("mid_rst_done2", 32'(done2), 32'd0);
        chk("mid_rst_ferr2", 32'(ferr2), 32'd0);
        chk("mid_rst_tx2", 32'(tx2), 32'd1);
        chk("mid_rst_cmd3", 32'(cmd3), 32'd0);
      end
    join
    idle(3);
    rst_n = 1'b1;
    idle(200);
    txq.delete();
    chk("post_rst_busy2", 32'(busy2), 32'd0);
    chk("post_rst_tx2", 32'(tx2), 32'd1);
    send_byte(2, 8'h12);
    chk("post_rst_first_rdy", 32'(rdy2), 32'd0);
    send_byte(2, 8'h34);
    chk("post_rst_cmd", 32'(cmd2), 32'h1234);
    chk("post_rst_rdy", 32'(rdy2), 32'd1);
    chk("post_rst_no_tx", 32'(txq.size()), 32'd0);
    chk("dut2_no_ferr", 32'(ferr2_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
